alu_rs: RTL and testbench

//  Reservation station directly upstream of the ALU. Buffers dispatched integer ops until both

---
 rtl/alu_rs_pkg.sv | 60 ++++++
 rtl/alu_rs_prio_enc.sv | 20 ++
 rtl/alu_rs.sv | 127 ++++++++++++
 tb/tb_alu_rs.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, ALU op encodings and reservation-station entry types.
// Also holds the operand capture helper used by both dispatch bypass and wakeup.
package alu_rs_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE_WIDTH_DEF = 3;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  localparam logic ALU_SRL = 1'b0;
  localparam logic ALU_SRA = 1'b1;

  typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic        qj_valid;
    rob_tag_t    qj;
    logic [31:0] vj;
    logic        qk_valid;
    rob_tag_t    qk;
    logic [31:0] vk;
    rob_tag_t    rob_id;
    logic [2:0]  op_l1;
    logic        op_l2;
  } rs_entry_t;

  typedef struct packed {
    logic        pending;
    logic [31:0] value;
  } operand_t;

  // ALU broadcast is checked first so it wins when both buses carry the tag.
  function automatic operand_t resolve(input logic pending, input rob_tag_t tag,
                                       input logic [31:0] value,
                                       input logic alu_rdy, input rob_tag_t alu_tag,
                                       input logic [31:0] alu_val,
                                       input logic lsb_rdy, input rob_tag_t lsb_tag,
                                       input logic [31:0] lsb_val);
    operand_t r;
    r.pending = pending;
    r.value   = value;
    if (pending && alu_rdy && alu_tag == tag) begin
      r.pending = 1'b0;
      r.value   = alu_val;
    end else if (pending && lsb_rdy && lsb_tag == tag) begin
      r.pending = 1'b0;
      r.value   = lsb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any request is set and
// the index of the lowest one.
module alu_rs_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] index
);

  always_comb begin
    found = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = W'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive,
// snoops both CDBs for wakeup and issues the lowest-index ready entry each cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE_WIDTH = RS_SIZE_WIDTH_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      disp_valid_in,
  input  logic [31:0]               disp_vj_in,
  input  logic [31:0]               disp_vk_in,
  input  logic                      disp_qj_valid_in,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qj_in,
  input  logic                      disp_qk_valid_in,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qk_in,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_rob_id_in,
  input  logic [2:0]                disp_op_L1_in,
  input  logic                      disp_op_L2_in,
  output logic                      full_out,
  input  logic                      cdb_alu_ready_in,
  input  logic [31:0]               cdb_alu_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_rob_id_in,
  input  logic                      cdb_lsb_ready_in,
  input  logic [31:0]               cdb_lsb_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_rob_id_in,
  output logic                      alu_valid_out,
  output logic [31:0]               alu_opr1_out,
  output logic [31:0]               alu_opr2_out,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id_out,
  output logic [2:0]                alu_op_L1_out,
  output logic                      alu_op_L2_out
);

  localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

  rs_entry_t                entry [RS_SIZE];
  logic [RS_SIZE-1:0]       busy;
  logic [RS_SIZE-1:0]       ready;
  logic                     free_found;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic                     issue_found;
  logic [RS_SIZE_WIDTH-1:0] issue_idx;
  operand_t                 disp_j;
  operand_t                 disp_k;
  operand_t                 wake_j [RS_SIZE];
  operand_t                 wake_k [RS_SIZE];

  assign full_out = &busy;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i]  = busy[i] & ~entry[i].qj_valid & ~entry[i].qk_valid;
      wake_j[i] = resolve(entry[i].qj_valid, entry[i].qj, entry[i].vj,
                          cdb_alu_ready_in, cdb_alu_rob_id_in, cdb_alu_value_in,
                          cdb_lsb_ready_in, cdb_lsb_rob_id_in, cdb_lsb_value_in);
      wake_k[i] = resolve(entry[i].qk_valid, entry[i].qk, entry[i].vk,
                          cdb_alu_ready_in, cdb_alu_rob_id_in, cdb_alu_value_in,
                          cdb_lsb_ready_in, cdb_lsb_rob_id_in, cdb_lsb_value_in);
    end
    disp_j = resolve(disp_qj_valid_in, disp_qj_in, disp_vj_in,
                     cdb_alu_ready_in, cdb_alu_rob_id_in, cdb_alu_value_in,
                     cdb_lsb_ready_in, cdb_lsb_rob_id_in, cdb_lsb_value_in);
    disp_k = resolve(disp_qk_valid_in, disp_qk_in, disp_vk_in,
                     cdb_alu_ready_in, cdb_alu_rob_id_in, cdb_alu_value_in,
                     cdb_lsb_ready_in, cdb_lsb_rob_id_in, cdb_lsb_value_in);
  end

  alu_rs_prio_enc #(.N(RS_SIZE)) u_free_sel (
    .req   (~busy),
    .found (free_found),
    .index (free_idx)
  );

  alu_rs_prio_enc #(.N(RS_SIZE)) u_issue_sel (
    .req   (ready),
    .found (issue_found),
    .index (issue_idx)
  );

  // Free slot comes from current busy bits, so a slot vacated by this cycle's issue waits a cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy           <= '0;
      alu_valid_out  <= 1'b0;
      alu_opr1_out   <= '0;
      alu_opr2_out   <= '0;
      alu_rob_id_out <= '0;
      alu_op_L1_out  <= '0;
      alu_op_L2_out  <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) entry[i] <= '0;
    end else if (!rdy_in) begin
      alu_valid_out <= 1'b0;
    end else if (need_flush_in) begin
      busy          <= '0;
      alu_valid_out <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          entry[i].qj_valid <= wake_j[i].pending;
          entry[i].vj       <= wake_j[i].value;
          entry[i].qk_valid <= wake_k[i].pending;
          entry[i].vk       <= wake_k[i].value;
        end
      end
      alu_valid_out <= issue_found;
      if (issue_found) begin
        busy[issue_idx] <= 1'b0;
        alu_opr1_out    <= entry[issue_idx].vj;
        alu_opr2_out    <= entry[issue_idx].vk;
        alu_rob_id_out  <= entry[issue_idx].rob_id;
        alu_op_L1_out   <= entry[issue_idx].op_l1;
        alu_op_L2_out   <= entry[issue_idx].op_l2;
      end
      if (disp_valid_in && free_found) begin
        busy[free_idx]  <= 1'b1;
        entry[free_idx] <= '{qj_valid: disp_j.pending, qj: disp_qj_in, vj: disp_j.value,
                             qk_valid: disp_k.pending, qk: disp_qk_in, vk: disp_k.value,
                             rob_id: disp_rob_id_in, op_l1: disp_op_L1_in,
                             op_l2: disp_op_L2_in};
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/CDB vectors push expected issues
// (including the expected issue cycle); a negedge monitor pops and compares.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in, rst_in, rdy_in, need_flush_in;
  logic        disp_valid_in;
  logic [31:0] disp_vj_in, disp_vk_in;
  logic        disp_qj_valid_in, disp_qk_valid_in;
  logic [3:0]  disp_qj_in, disp_qk_in, disp_rob_id_in;
  logic [2:0]  disp_op_L1_in;
  logic        disp_op_L2_in;
  logic        full_out;
  logic        cdb_alu_ready_in, cdb_lsb_ready_in;
  logic [31:0] cdb_alu_value_in, cdb_lsb_value_in;
  logic [3:0]  cdb_alu_rob_id_in, cdb_lsb_rob_id_in;
  logic        alu_valid_out;
  logic [31:0] alu_opr1_out, alu_opr2_out;
  logic [3:0]  alu_rob_id_out;
  logic [2:0]  alu_op_L1_out;
  logic        alu_op_L2_out;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .disp_valid_in(disp_valid_in), .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
    .disp_qj_valid_in(disp_qj_valid_in), .disp_qj_in(disp_qj_in),
    .disp_qk_valid_in(disp_qk_valid_in), .disp_qk_in(disp_qk_in),
    .disp_rob_id_in(disp_rob_id_in), .disp_op_L1_in(disp_op_L1_in),
    .disp_op_L2_in(disp_op_L2_in), .full_out(full_out),
    .cdb_alu_ready_in(cdb_alu_ready_in), .cdb_alu_value_in(cdb_alu_value_in),
    .cdb_alu_rob_id_in(cdb_alu_rob_id_in),
    .cdb_lsb_ready_in(cdb_lsb_ready_in), .cdb_lsb_value_in(cdb_lsb_value_in),
    .cdb_lsb_rob_id_in(cdb_lsb_rob_id_in),
    .alu_valid_out(alu_valid_out), .alu_opr1_out(alu_opr1_out), .alu_opr2_out(alu_opr2_out),
    .alu_rob_id_out(alu_rob_id_out), .alu_op_L1_out(alu_op_L1_out),
    .alu_op_L2_out(alu_op_L2_out)
  );

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [3:0]  rob;
    logic [2:0]  l1;
    logic        l2;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  always @(negedge clk_in) begin
    if (!rst_in && alu_valid_out) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_issue: got rob=%0d opr1=%h opr2=%h cyc=%0d expected no issue",
                 alu_rob_id_out, alu_opr1_out, alu_opr2_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (alu_opr1_out == mon_e.o1 && alu_opr2_out == mon_e.o2 &&
            alu_rob_id_out == mon_e.rob && alu_op_L1_out == mon_e.l1 &&
            alu_op_L2_out == mon_e.l2 && cyc == mon_e.cyc)
          passed++;
        else
          $display("FAIL issue: got opr1=%h opr2=%h rob=%0d l1=%0d l2=%0d cyc=%0d expected opr1=%h opr2=%h rob=%0d l1=%0d l2=%0d cyc=%0d",
                   alu_opr1_out, alu_opr2_out, alu_rob_id_out, alu_op_L1_out, alu_op_L2_out, cyc,
                   mon_e.o1, mon_e.o2, mon_e.rob, mon_e.l1, mon_e.l2, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic clear_in();
    disp_valid_in    = 1'b0;
    disp_qj_valid_in = 1'b0;
    disp_qk_valid_in = 1'b0;
    cdb_alu_ready_in = 1'b0;
    cdb_lsb_ready_in = 1'b0;
    need_flush_in    = 1'b0;
  endtask

  task automatic disp(input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjv, input logic [3:0] qj,
                      input logic qkv, input logic [3:0] qk,
                      input logic [3:0] rob, input logic [2:0] l1, input logic l2);
    disp_valid_in    = 1'b1;
    disp_vj_in       = vj;
    disp_vk_in       = vk;
    disp_qj_valid_in = qjv;
    disp_qj_in       = qj;
    disp_qk_valid_in = qkv;
    disp_qk_in       = qk;
    disp_rob_id_in   = rob;
    disp_op_L1_in    = l1;
    disp_op_L2_in    = l2;
  endtask

  task automatic cdb_alu(input logic [3:0] rob, input logic [31:0] val);
    cdb_alu_ready_in  = 1'b1;
    cdb_alu_rob_id_in = rob;
    cdb_alu_value_in  = val;
  endtask

  task automatic cdb_lsb(input logic [3:0] rob, input logic [31:0] val);
    cdb_lsb_ready_in  = 1'b1;
    cdb_lsb_rob_id_in = rob;
    cdb_lsb_value_in  = val;
  endtask

  task automatic expect_issue(input logic [31:0] o1, input logic [31:0] o2, input logic [3:0] rob,
                              input logic [2:0] l1, input logic l2, input int at);
    exp_t e;
    e.o1 = o1; e.o2 = o2; e.rob = rob; e.l1 = l1; e.l2 = l2; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_in();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid_in = 1'b0;
    cdb_alu(0, 0);
    cdb_lsb(0, 0);
    clear_in();
    repeat (2) tick();
    check("reset_valid", alu_valid_out, 0);
    check("reset_full", full_out, 0);
    check("reset_opr1", alu_opr1_out, 0);
    rst_in = 1'b0;
    tick();

    // ready ADD
    disp(3, 4, 0, 0, 0, 0, 2, ALU_ADD_SUB, ALU_ADD);
    expect_issue(3, 4, 2, ALU_ADD_SUB, ALU_ADD, cyc + 2);
    tick(); clear_in(); tick(); tick();

    // SUB woken by ALU CDB, then by LSB CDB
    disp(0, 1, 1, 5, 0, 0, 3, ALU_ADD_SUB, ALU_SUB);
    tick(); clear_in(); tick();
    cdb_alu(5, 10);
    expect_issue(10, 1, 3, ALU_ADD_SUB, ALU_SUB, cyc + 2);
    tick(); clear_in(); tick(); tick();
    disp(0, 1, 1, 5, 0, 0, 4, ALU_ADD_SUB, ALU_SUB);
    tick(); clear_in(); tick();
    cdb_lsb(5, 10);
    expect_issue(10, 1, 4, ALU_ADD_SUB, ALU_SUB, cyc + 2);
    tick(); clear_in(); tick(); tick();

    // dispatch-cycle bypass from LSB; then both CDBs on qk, ALU wins
    disp(0, 5, 1, 7, 0, 0, 5, ALU_XOR, 0);
    cdb_lsb(7, 32'hDEAD);
    expect_issue(32'hDEAD, 5, 5, ALU_XOR, 0, cyc + 2);
    tick(); clear_in();
    disp(9, 0, 0, 0, 1, 6, 6, ALU_OR, 0);
    cdb_alu(6, 32'h111);
    cdb_lsb(6, 32'h222);
    expect_issue(9, 32'h111, 6, ALU_OR, 0, cyc + 2);
    tick(); clear_in(); tick(); tick();

    // wakeup of a busy entry with both CDBs matching: ALU wins
    disp(0, 32'h77, 1, 3, 0, 0, 7, ALU_SRL_SRA, ALU_SRA);
    tick(); clear_in();
    cdb_alu(3, 32'hA);
    cdb_lsb(3, 32'hB);
    expect_issue(32'hA, 32'h77, 7, ALU_SRL_SRA, ALU_SRA, cyc + 2);
    tick(); clear_in(); tick(); tick();

    // fill all 8 entries waiting on tags 8..15
    for (int i = 0; i < 8; i++) begin
      disp(0, 32'h100 + i, 1, 4'(8 + i), 0, 0, 4'(i), ALU_AND, 0);
      tick(); clear_in();
    end
    check("full_set", full_out, 1);
    disp(1, 1, 0, 0, 0, 0, 15, ALU_ADD_SUB, 0);
    tick(); clear_in();
    check("full_after_drop", full_out, 1);
    cdb_alu(11, 32'h33);
    expect_issue(32'h33, 32'h103, 3, ALU_AND, 0, cyc + 2);
    tick(); clear_in();
    check("full_before_issue", full_out, 1);
    disp(2, 2, 0, 0, 0, 0, 14, ALU_ADD_SUB, 0);
    tick(); clear_in();
    check("full_after_issue", full_out, 0);
    tick(); tick();

    // flush with simultaneous dispatch; later broadcasts must not issue anything
    need_flush_in = 1'b1;
    disp(3, 3, 0, 0, 0, 0, 13, ALU_ADD_SUB, 0);
    tick(); clear_in();
    check("flush_full", full_out, 0);
    for (int t = 8; t < 16; t += 2) begin
      cdb_alu(4'(t), 32'(t));
      cdb_lsb(4'(t + 1), 32'(t));
      tick(); clear_in();
    end
    tick(); tick();

    // rdy_in low for 3 cycles freezes everything, including flush and CDB
    disp(0, 32'h40, 1, 2, 0, 0, 9, ALU_ADD_SUB, 0);
    tick(); clear_in();
    disp(1, 2, 0, 0, 0, 0, 10, ALU_SLL, 0);
    tick();
    rdy_in = 1'b0;
    need_flush_in = 1'b1;
    disp(32'hAA, 0, 0, 0, 0, 0, 11, ALU_ADD_SUB, 0);
    cdb_alu(2, 7);
    repeat (3) begin
      tick();
      check("frozen_valid", alu_valid_out, 0);
    end
    rdy_in = 1'b1;
    clear_in();
    expect_issue(1, 2, 10, ALU_SLL, 0, cyc + 1);
    tick(); tick();
    cdb_lsb(2, 7);
    expect_issue(7, 32'h40, 9, ALU_ADD_SUB, 0, cyc + 2);
    tick(); clear_in(); tick(); tick();

    // async reset mid-run with 5 waiting entries and an issue on the outputs
    for (int i = 0; i < 5; i++) begin
      disp(0, 0, 1, 12, 0, 0, 4'(i + 1), ALU_ADD_SUB, 0);
      tick(); clear_in();
    end
    disp(5, 6, 0, 0, 0, 0, 6, ALU_ADD_SUB, 0);
    expect_issue(5, 6, 6, ALU_ADD_SUB, 0, cyc + 2);
    tick(); clear_in(); tick();
    check("pre_reset_valid", alu_valid_out, 1);
    rst_in = 1'b1;
    #1;
    check("async_reset_valid", alu_valid_out, 0);
    check("async_reset_opr1", alu_opr1_out, 0);
    check("async_reset_rob", alu_rob_id_out, 0);
    check("async_reset_full", full_out, 0);
    tick();
    rst_in = 1'b0;
    tick();
    cdb_alu(12, 1);
    tick(); clear_in();
    repeat (3) tick();

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
